ahb3lite_dma_arbiter: RTL and testbench

AHB3LITE_DMA_ARBITER -- requirements
Module: ahb3lite_dma_arbiter

---
 rtl/ahb3lite_dma_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_ahb3lite_dma_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ahb3lite_dma_arbiter.sv
// Round-robin arbiter sharing one AHB3-Lite slave port among NUM_M DMA write masters.
// Grants move only on owner IDLE with HREADY=1, so bursts are never split.
module ahb3lite_dma_arbiter #(
    parameter int NUM_M      = 3,
    parameter int BUSY_LIMIT = 16
) (
    input  logic                HCLK,
    input  logic                HRESET,
    input  logic [NUM_M-1:0]    m_req,
    output logic [NUM_M-1:0]    m_grant,
    input  logic [NUM_M*32-1:0] m_HADDR,
    input  logic [NUM_M*32-1:0] m_HWDATA,
    input  logic [NUM_M-1:0]    m_HWRITE,
    input  logic [NUM_M*2-1:0]  m_HTRANS,
    input  logic [NUM_M*3-1:0]  m_HBURST,
    input  logic [NUM_M*3-1:0]  m_HSIZE,
    output logic [31:0]         HADDR,
    output logic [31:0]         HWDATA,
    output logic                HWRITE,
    output logic [1:0]          HTRANS,
    output logic [2:0]          HBURST,
    output logic [2:0]          HSIZE,
    input  logic                HREADY,
    input  logic                HRESP,
    output logic [1:0]          HMASTER,
    output logic [1:0]          HMASTER_D,
    output logic                busy_err
);
    localparam logic [1:0] TR_IDLE = 2'd0;
    localparam logic [1:0] TR_BUSY = 2'd1;

    typedef enum logic [1:0] {NO_OWNER, OWNED, HANDOVER} state_t;

    state_t             state, state_nxt;
    logic [NUM_M-1:0]   grant_nxt;
    logic [1:0]         owner_nxt, last_owner, last_nxt, winner, winner_nxt;
    logic [4:0]         busy_cnt, busy_nxt;

    logic [31:0]        own_addr;
    logic               own_write;
    logic [1:0]         own_trans;
    logic [2:0]         own_burst, own_size;

    logic [NUM_M-1:0]   req_mask;
    logic               rr_found;
    logic [1:0]         rr_idx, cand;
    logic               arb_point, own_busy;

    // Masters take HREADY/HRESP straight from the slave; HRESP has no use inside.
    logic               hresp_unused;
    assign hresp_unused = HRESP;

    function automatic logic [NUM_M-1:0] onehot(input logic [1:0] idx);
        logic [NUM_M-1:0] oh;
        oh = '0;
        for (int k = 0; k < NUM_M; k++)
            if (idx == 2'(k)) oh[k] = 1'b1;
        return oh;
    endfunction

    always_comb begin
        own_addr  = '0;
        own_write = 1'b0;
        own_trans = TR_IDLE;
        own_burst = '0;
        own_size  = '0;
        HWDATA    = m_HWDATA[31:0];
        for (int i = 0; i < NUM_M; i++) begin
            if (HMASTER == 2'(i)) begin
                own_addr  = m_HADDR[i*32 +: 32];
                own_write = m_HWRITE[i];
                own_trans = m_HTRANS[i*2 +: 2];
                own_burst = m_HBURST[i*3 +: 3];
                own_size  = m_HSIZE[i*3 +: 3];
            end
            // Data phase follows HMASTER_D so a pending beat finishes across handover.
            if (HMASTER_D == 2'(i))
                HWDATA = m_HWDATA[i*32 +: 32];
        end
    end

    always_comb begin
        HADDR  = '0;
        HWRITE = 1'b0;
        HTRANS = TR_IDLE;
        HBURST = '0;
        HSIZE  = '0;
        if (state == OWNED) begin
            HADDR  = own_addr;
            HWRITE = own_write;
            HTRANS = own_trans;
            HBURST = own_burst;
            HSIZE  = own_size;
        end
    end

    // Search starts after last_owner; while owned, the owner itself is masked out.
    always_comb begin
        req_mask = (state == OWNED) ? (m_req & ~m_grant) : m_req;
        rr_found = 1'b0;
        rr_idx   = '0;
        cand     = '0;
        for (int k = 1; k <= NUM_M; k++) begin
            cand = 2'((int'(last_owner) + k) % NUM_M);
            if (!rr_found && req_mask[cand]) begin
                rr_found = 1'b1;
                rr_idx   = cand;
            end
        end
    end

    assign arb_point = (state == OWNED) && HREADY && (own_trans == TR_IDLE);
    assign own_busy  = (state == OWNED) && (own_trans == TR_BUSY);

    always_comb begin
        state_nxt  = state;
        grant_nxt  = m_grant;
        owner_nxt  = HMASTER;
        last_nxt   = last_owner;
        winner_nxt = winner;
        case (state)
            NO_OWNER: begin
                if (rr_found) begin
                    state_nxt = OWNED;
                    grant_nxt = onehot(rr_idx);
                    owner_nxt = rr_idx;
                    last_nxt  = rr_idx;
                end
            end
            OWNED: begin
                if (arb_point) begin
                    if (rr_found) begin
                        state_nxt  = HANDOVER;
                        grant_nxt  = '0;
                        winner_nxt = rr_idx;
                    end else if ((m_req & m_grant) == '0) begin
                        state_nxt = NO_OWNER;
                        grant_nxt = '0;
                    end
                end
            end
            HANDOVER: begin
                state_nxt = OWNED;
                grant_nxt = onehot(winner);
                owner_nxt = winner;
                last_nxt  = winner;
            end
            default: begin
                state_nxt = NO_OWNER;
                grant_nxt = '0;
            end
        endcase
    end

    always_comb begin
        busy_nxt = '0;
        if (own_busy && grant_nxt == m_grant)
            busy_nxt = (busy_cnt == 5'h1f) ? busy_cnt : busy_cnt + 5'd1;
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state      <= NO_OWNER;
            m_grant    <= '0;
            HMASTER    <= '0;
            HMASTER_D  <= '0;
            last_owner <= 2'(NUM_M - 1);
            winner     <= '0;
            busy_cnt   <= '0;
            busy_err   <= 1'b0;
        end else begin
            state      <= state_nxt;
            m_grant    <= grant_nxt;
            HMASTER    <= owner_nxt;
            last_owner <= last_nxt;
            winner     <= winner_nxt;
            busy_cnt   <= busy_nxt;
            if (HREADY)
                HMASTER_D <= HMASTER;
            if ({27'b0, busy_nxt} >= 32'(BUSY_LIMIT))
                busy_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ahb3lite_dma_arbiter.sv
// Directed bench for ahb3lite_dma_arbiter: per-cycle vector table plus
// hand-written BUSY-stall and BUSY-limit sequences.
module tb_ahb3lite_dma_arbiter;
    localparam int NM = 3;

    logic            HCLK, HRESET;
    logic [NM-1:0]   m_req, m_grant, m_HWRITE;
    logic [NM*32-1:0] m_HADDR, m_HWDATA;
    logic [NM*2-1:0] m_HTRANS;
    logic [NM*3-1:0] m_HBURST, m_HSIZE;
    logic [31:0]     HADDR, HWDATA;
    logic            HWRITE, HREADY, HRESP, busy_err;
    logic [1:0]      HTRANS, HMASTER, HMASTER_D;
    logic [2:0]      HBURST, HSIZE;

    ahb3lite_dma_arbiter #(.NUM_M(NM), .BUSY_LIMIT(16)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .m_req(m_req), .m_grant(m_grant),
        .m_HADDR(m_HADDR), .m_HWDATA(m_HWDATA), .m_HWRITE(m_HWRITE),
        .m_HTRANS(m_HTRANS), .m_HBURST(m_HBURST), .m_HSIZE(m_HSIZE),
        .HADDR(HADDR), .HWDATA(HWDATA), .HWRITE(HWRITE), .HTRANS(HTRANS),
        .HBURST(HBURST), .HSIZE(HSIZE), .HREADY(HREADY), .HRESP(HRESP),
        .HMASTER(HMASTER), .HMASTER_D(HMASTER_D), .busy_err(busy_err)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    typedef struct {
        logic       rst;
        logic [2:0] req;
        logic [5:0] tr;
        logic       rdy;
        logic [2:0] g;
        logic [1:0] ht, hm, hmd;
        int         sel;
    } vec_t;

    vec_t vq[$];
    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] addr_of(input int s);
        return (s < 0) ? 32'h0 : 32'hA000_0000 + 32'(s) * 32'h100;
    endfunction
    function automatic logic [31:0] data_of(input int s);
        return 32'hD000_0000 + 32'(s) * 32'h11;
    endfunction
    // {HWRITE, HBURST, HSIZE}: m0 write INCR4 word, m1 read INCR4 half, m2 write INCR8 byte
    function automatic logic [6:0] ctl_of(input int s);
        case (s)
            0:       return {1'b1, 3'd3, 3'd2};
            1:       return {1'b0, 3'd3, 3'd1};
            2:       return {1'b1, 3'd5, 3'd0};
            default: return 7'd0;
        endcase
    endfunction
    function automatic logic [5:0] tr(input logic [1:0] t0, t1, t2);
        return {t2, t1, t0};
    endfunction

    task automatic add(input logic r, input logic [2:0] q, input logic [5:0] t, input logic rdy,
                       input logic [2:0] g, input logic [1:0] ht, hm, hmd, input int sel);
        vec_t v;
        v.rst = r; v.req = q; v.tr = t; v.rdy = rdy;
        v.g = g; v.ht = ht; v.hm = hm; v.hmd = hmd; v.sel = sel;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step(input logic [2:0] q, input logic [5:0] t, input logic rdy);
        @(negedge HCLK);
        HRESET = 1'b0; m_req = q; m_HTRANS = t; HREADY = rdy;
        #1;
    endtask

    initial begin
        HRESET = 1'b1; m_req = '0; m_HTRANS = '0; HREADY = 1'b1; HRESP = 1'b0;
        for (int i = 0; i < NM; i++) begin
            m_HADDR[i*32 +: 32]  = addr_of(i);
            m_HWDATA[i*32 +: 32] = data_of(i);
            {m_HWRITE[i], m_HBURST[i*3 +: 3], m_HSIZE[i*3 +: 3]} = ctl_of(i);
        end
        #2;
        chk("rst grant", 32'(m_grant), 0);
        chk("rst htrans", 32'(HTRANS), 0);
        chk("rst haddr", HADDR, 0);
        chk("rst hmaster", 32'(HMASTER), 0);
        chk("rst hmaster_d", 32'(HMASTER_D), 0);
        chk("rst hwdata", HWDATA, data_of(0));
        chk("rst busy_err", 32'(busy_err), 0);

        // All three request; each does INCR4 then IDLE: grants 0,1,2,0 with a handover gap.
        add(0,3'b111,tr(0,1,1),1, 3'b000,0,0,0,-1);
        add(0,3'b111,tr(2,1,1),1, 3'b001,2,0,0, 0);
        add(0,3'b111,tr(3,1,1),1, 3'b001,3,0,0, 0);
        add(0,3'b111,tr(3,1,1),1, 3'b001,3,0,0, 0);
        add(0,3'b111,tr(3,1,1),1, 3'b001,3,0,0, 0);
        add(0,3'b111,tr(0,1,1),1, 3'b001,0,0,0, 0);
        add(0,3'b111,tr(0,1,1),1, 3'b000,0,0,0,-1);
        add(0,3'b111,tr(1,2,1),1, 3'b010,2,1,0, 1);
        add(0,3'b111,tr(1,3,1),1, 3'b010,3,1,1, 1);
        add(0,3'b111,tr(1,3,1),1, 3'b010,3,1,1, 1);
        add(0,3'b111,tr(1,3,1),1, 3'b010,3,1,1, 1);
        add(0,3'b111,tr(1,0,1),1, 3'b010,0,1,1, 1);
        add(0,3'b111,tr(1,0,1),1, 3'b000,0,1,1,-1);
        add(0,3'b111,tr(1,1,2),1, 3'b100,2,2,1, 2);
        add(0,3'b111,tr(1,1,3),1, 3'b100,3,2,2, 2);
        add(0,3'b111,tr(1,1,3),1, 3'b100,3,2,2, 2);
        add(0,3'b111,tr(1,1,3),1, 3'b100,3,2,2, 2);
        add(0,3'b111,tr(1,1,0),1, 3'b100,0,2,2, 2);
        add(0,3'b111,tr(1,1,0),1, 3'b000,0,2,2,-1);
        add(0,3'b111,tr(2,1,1),1, 3'b001,2,0,2, 0);
        // Reset, then master 1 alone; last beat stalled by HREADY=0, handover to 2.
        add(1,3'b010,tr(1,2,1),1, 3'b000,0,0,0,-1);
        add(0,3'b010,tr(1,1,1),1, 3'b000,0,0,0,-1);
        add(0,3'b110,tr(1,2,1),1, 3'b010,2,1,0, 1);
        add(0,3'b110,tr(1,3,1),1, 3'b010,3,1,1, 1);
        add(0,3'b110,tr(1,3,1),1, 3'b010,3,1,1, 1);
        add(0,3'b110,tr(1,3,1),1, 3'b010,3,1,1, 1);
        add(0,3'b110,tr(1,0,1),0, 3'b010,0,1,1, 1);
        add(0,3'b110,tr(1,0,1),0, 3'b010,0,1,1, 1);
        add(0,3'b110,tr(1,0,1),1, 3'b010,0,1,1, 1);
        add(0,3'b110,tr(1,0,1),1, 3'b000,0,1,1,-1);
        add(0,3'b110,tr(1,1,2),0, 3'b100,2,2,1, 2);
        add(0,3'b110,tr(1,1,2),1, 3'b100,2,2,1, 2);
        // Parking with only the owner requesting, then release to NO_OWNER.
        add(0,3'b100,tr(1,1,0),1, 3'b100,0,2,2, 2);
        add(0,3'b100,tr(1,1,0),1, 3'b100,0,2,2, 2);
        add(0,3'b000,tr(1,1,0),1, 3'b100,0,2,2, 2);
        add(0,3'b000,tr(1,1,1),1, 3'b000,0,2,2,-1);
        // Reset hitting master 1 mid-SEQ, then a one-cycle regrant to master 1.
        add(0,3'b010,tr(1,1,1),1, 3'b000,0,2,2,-1);
        add(0,3'b010,tr(1,2,1),1, 3'b010,2,1,2, 1);
        add(0,3'b010,tr(1,3,1),1, 3'b010,3,1,1, 1);
        add(1,3'b010,tr(1,3,1),1, 3'b000,0,0,0,-1);
        add(0,3'b010,tr(1,1,1),1, 3'b000,0,0,0,-1);
        add(0,3'b010,tr(1,2,1),1, 3'b010,2,1,0, 1);

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge HCLK);
            HRESET = vq[i].rst; m_req = vq[i].req; m_HTRANS = vq[i].tr; HREADY = vq[i].rdy;
            #1;
            chk($sformatf("v%0d grant", i), 32'(m_grant), 32'(vq[i].g));
            chk($sformatf("v%0d htrans", i), 32'(HTRANS), 32'(vq[i].ht));
            chk($sformatf("v%0d hmaster", i), 32'(HMASTER), 32'(vq[i].hm));
            chk($sformatf("v%0d hmaster_d", i), 32'(HMASTER_D), 32'(vq[i].hmd));
            chk($sformatf("v%0d haddr", i), HADDR, addr_of(vq[i].sel));
            chk($sformatf("v%0d hwdata", i), HWDATA, data_of(int'(vq[i].hmd)));
            chk($sformatf("v%0d ctl", i), 32'({HWRITE, HBURST, HSIZE}), 32'(ctl_of(vq[i].sel)));
        end

        // Owner 0 inserts BUSY cycles while master 2 requests: no early handover.
        @(negedge HCLK); HRESET = 1'b1; m_req = '0; #1;
        step(3'b001, tr(0,1,1), 1); chk("b grant idle", 32'(m_grant), 0);
        step(3'b101, tr(2,1,1), 1); chk("b grant nonseq", 32'(m_grant), 3'b001);
        step(3'b101, tr(3,1,1), 1); chk("b grant seq", 32'(m_grant), 3'b001);
        for (int i = 0; i < 3; i++) begin
            step(3'b101, tr(1,1,1), 1);
            chk($sformatf("b busy%0d grant", i), 32'(m_grant), 3'b001);
            chk($sformatf("b busy%0d htrans", i), 32'(HTRANS), 1);
        end
        step(3'b101, tr(3,1,1), 1); chk("b grant seq2", 32'(m_grant), 3'b001);
        step(3'b101, tr(0,1,1), 0); chk("b grant idle stall", 32'(m_grant), 3'b001);
        step(3'b101, tr(0,1,1), 1); chk("b grant idle ready", 32'(m_grant), 3'b001);
        step(3'b101, tr(1,1,1), 1); chk("b handover grant", 32'(m_grant), 0);
        chk("b handover htrans", 32'(HTRANS), 0);
        step(3'b101, tr(1,1,2), 1); chk("b grant m2", 32'(m_grant), 3'b100);
        chk("b hmaster m2", 32'(HMASTER), 2);

        // Master 2: 10 BUSY, one SEQ (clears the count), then 16 consecutive BUSY.
        for (int i = 0; i < 10; i++) step(3'b101, tr(1,1,1), 1);
        chk("c busy_err after 10", 32'(busy_err), 0);
        step(3'b101, tr(1,1,3), 1);
        for (int i = 0; i < 16; i++) begin
            step(3'b101, tr(1,1,1), 1);
            chk($sformatf("c busy_err pre%0d", i), 32'(busy_err), 0);
        end
        step(3'b101, tr(1,1,1), 1);
        chk("c busy_err at limit", 32'(busy_err), 1);
        chk("c grant kept", 32'(m_grant), 3'b100);
        step(3'b101, tr(1,1,0), 1); chk("c grant at idle", 32'(m_grant), 3'b100);
        step(3'b101, tr(1,1,1), 1); chk("c handover grant", 32'(m_grant), 0);
        step(3'b101, tr(2,1,1), 1); chk("c grant m0", 32'(m_grant), 3'b001);
        chk("c busy_err sticky", 32'(busy_err), 1);
        @(negedge HCLK); HRESET = 1'b1; #1;
        chk("c busy_err reset", 32'(busy_err), 0);
        chk("c grant reset", 32'(m_grant), 0);
        step(3'b000, tr(0,0,0), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
